ddma_send_scheduler: RTL and testbench

- Queues DMA send descriptors (destination, RAM address, byte size) written by the CPU over MMIO.
- Issues the descriptors to the DDMA send engine one at a time, in FIFO order.
- Performs the command/busy handshake with the engine, counts completions and raises a sticky completion interrupt.
- Sits between the PE MMIO write decode and the ddma send_* inputs. It replaces direct CPU writes to the send_dest/addr/size/cmd registers.

---
 rtl/ddma_send_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_ddma_send_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddma_send_scheduler.sv
// ddma_send_scheduler: queues CPU-written DMA send descriptors and issues them
// one at a time, in FIFO order, to the DDMA send engine.
//
// Ports:
//   clock, reset            clock; synchronous active-low reset
//   push_valid_in           descriptor write strobe (dest/addr/size below)
//   push_dest_in/_addr_in/_size_in  descriptor fields
//   push_ready_out          1 while the queue has a free slot (from count)
//   flush_in                drop every queued, not-yet-issued descriptor
//   ddma_send_dest/addr/size_out    descriptor presented to the engine
//   ddma_send_cmd_out       start command, held until the engine goes busy
//   ddma_send_busy_in       engine busy
//   count_out               descriptors currently queued
//   done_count_out          completed descriptors since reset (wrapping)
//   irq_done_out            sticky completion interrupt, cleared by irq_ack_in
//   irq_ack_in              interrupt acknowledge
//   timeout_err_out         sticky: engine never went busy after a command
module ddma_send_scheduler #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned DEST_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push_valid_in,
  input  logic [DEST_WIDTH-1:0]         push_dest_in,
  input  logic [31:0]                   push_addr_in,
  input  logic [31:0]                   push_size_in,
  output logic                          push_ready_out,
  input  logic                          flush_in,
  output logic [DEST_WIDTH-1:0]         ddma_send_dest_out,
  output logic [31:0]                   ddma_send_addr_out,
  output logic [31:0]                   ddma_send_size_out,
  output logic                          ddma_send_cmd_out,
  input  logic                          ddma_send_busy_in,
  output logic [$clog2(DEPTH+1)-1:0]    count_out,
  output logic [31:0]                   done_count_out,
  output logic                          irq_done_out,
  input  logic                          irq_ack_in,
  output logic                          timeout_err_out
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic [DEST_WIDTH-1:0] dest;
    logic [31:0]           addr;
    logic [31:0]           size;
  } desc_t;

  desc_t                 mem_q [DEPTH];
  logic [1:0]            state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  desc_t                 out_q, out_d;
  logic                  cmd_q, cmd_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic [31:0]           done_q, done_d;
  logic                  irq_q, irq_d;
  logic                  tmo_q, tmo_d;
  logic                  push_acc;
  logic                  pop;
  desc_t                 head;
  desc_t                 push_desc;

  assign push_ready_out = (count_q != CW'(DEPTH));
  assign head           = mem_q[rd_ptr_q];
  assign push_desc      = '{dest: push_dest_in, addr: push_addr_in, size: push_size_in};

  // Next-state: issue FSM, FIFO pointers/count, counters and sticky flags
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    out_d    = out_q;
    cmd_d    = cmd_q;
    wait_d   = wait_q;
    done_d   = done_q;
    irq_d    = irq_q;
    tmo_d    = tmo_q;
    pop      = 1'b0;
    // a flush in the same cycle wins over a push
    push_acc = push_valid_in && push_ready_out && !flush_in;

    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && !ddma_send_busy_in && !flush_in) begin
          pop    = 1'b1;
          out_d  = head;
          wait_d = '0;
          // zero-byte transfers complete without involving the engine
          if (head.size == 32'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            cmd_d   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (ddma_send_busy_in) begin
          cmd_d   = 1'b0;
          state_d = S_RUN;
        end else if (wait_q == WW'(TIMEOUT_CYCLES - 1)) begin
          cmd_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_RUN: begin
        if (!ddma_send_busy_in) begin
          state_d = S_DONE;
        end
      end
      default: begin
        done_d  = done_q + 32'd1;
        state_d = S_IDLE;
      end
    endcase

    // completion set takes priority over a coincident acknowledge
    if (irq_ack_in) begin
      irq_d = 1'b0;
    end
    if (state_q == S_DONE) begin
      irq_d = 1'b1;
    end

    if (flush_in) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push_acc) - CW'(pop);
    end
  end

  // State and storage registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      cmd_q    <= 1'b0;
      wait_q   <= '0;
      done_q   <= '0;
      irq_q    <= 1'b0;
      tmo_q    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      cmd_q    <= cmd_d;
      wait_q   <= wait_d;
      done_q   <= done_d;
      irq_q    <= irq_d;
      tmo_q    <= tmo_d;
      if (push_acc) begin
        mem_q[wr_ptr_q] <= push_desc;
      end
    end
  end

  assign ddma_send_dest_out = out_q.dest;
  assign ddma_send_addr_out = out_q.addr;
  assign ddma_send_size_out = out_q.size;
  assign ddma_send_cmd_out  = cmd_q;
  assign count_out          = count_q;
  assign done_count_out     = done_q;
  assign irq_done_out       = irq_q;
  assign timeout_err_out    = tmo_q;

endmodule

// File: tb/tb_ddma_send_scheduler.sv
// Directed bench for ddma_send_scheduler (DEPTH=4, TIMEOUT_CYCLES=8).
module tb_ddma_send_scheduler;

  logic        clock;
  logic        reset;
  logic        push_valid_in;
  logic [15:0] push_dest_in;
  logic [31:0] push_addr_in;
  logic [31:0] push_size_in;
  logic        push_ready_out;
  logic        flush_in;
  logic [15:0] ddma_send_dest_out;
  logic [31:0] ddma_send_addr_out;
  logic [31:0] ddma_send_size_out;
  logic        ddma_send_cmd_out;
  logic        ddma_send_busy_in;
  logic [2:0]  count_out;
  logic [31:0] done_count_out;
  logic        irq_done_out;
  logic        irq_ack_in;
  logic        timeout_err_out;

  int checks = 0;
  int errors = 0;

  ddma_send_scheduler #(
    .DEPTH(4),
    .DEST_WIDTH(16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .push_valid_in      (push_valid_in),
    .push_dest_in       (push_dest_in),
    .push_addr_in       (push_addr_in),
    .push_size_in       (push_size_in),
    .push_ready_out     (push_ready_out),
    .flush_in           (flush_in),
    .ddma_send_dest_out (ddma_send_dest_out),
    .ddma_send_addr_out (ddma_send_addr_out),
    .ddma_send_size_out (ddma_send_size_out),
    .ddma_send_cmd_out  (ddma_send_cmd_out),
    .ddma_send_busy_in  (ddma_send_busy_in),
    .count_out          (count_out),
    .done_count_out     (done_count_out),
    .irq_done_out       (irq_done_out),
    .irq_ack_in         (irq_ack_in),
    .timeout_err_out    (timeout_err_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [31:0] a, input logic [31:0] s);
    push_valid_in = 1'b1;
    push_dest_in  = d;
    push_addr_in  = a;
    push_size_in  = s;
  endtask

  // Bounded wait for the command strobe
  task automatic wait_cmd(input string tag);
    int n = 0;
    while (ddma_send_cmd_out !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 64'(ddma_send_cmd_out), 64'd1);
  endtask

  initial begin
    int hi;
    logic seen;
    reset = 1'b0;
    push_valid_in = 1'b0;
    push_dest_in = '0;
    push_addr_in = '0;
    push_size_in = '0;
    flush_in = 1'b0;
    ddma_send_busy_in = 1'b0;
    irq_ack_in = 1'b0;
    repeat (3) tick();

    // reset state
    check("rst_count", 64'(count_out), 64'd0);
    check("rst_ready", 64'(push_ready_out), 64'd1);
    check("rst_cmd", 64'(ddma_send_cmd_out), 64'd0);
    check("rst_dest", 64'(ddma_send_dest_out), 64'd0);
    check("rst_done", 64'(done_count_out), 64'd0);
    check("rst_irq", 64'(irq_done_out), 64'd0);
    check("rst_tmo", 64'(timeout_err_out), 64'd0);

    // single descriptor, engine busy for 10 cycles
    reset = 1'b1;
    push(16'h0101, 32'h4000_0100, 32'd64);
    tick();
    push_valid_in = 1'b0;
    check("t1_count1", 64'(count_out), 64'd1);
    check("t1_cmd_early", 64'(ddma_send_cmd_out), 64'd0);
    tick();
    check("t1_cmd", 64'(ddma_send_cmd_out), 64'd1);
    check("t1_dest", 64'(ddma_send_dest_out), 64'h0101);
    check("t1_addr", 64'(ddma_send_addr_out), 64'h4000_0100);
    check("t1_size", 64'(ddma_send_size_out), 64'd64);
    check("t1_count0", 64'(count_out), 64'd0);
    tick();
    tick();
    check("t1_cmd_held", 64'(ddma_send_cmd_out), 64'd1);
    ddma_send_busy_in = 1'b1;
    tick();
    check("t1_cmd_drop", 64'(ddma_send_cmd_out), 64'd0);
    repeat (9) tick();
    ddma_send_busy_in = 1'b0;
    tick();
    check("t1_done_pre", 64'(done_count_out), 64'd0);
    tick();
    check("t1_done", 64'(done_count_out), 64'd1);
    check("t1_irq", 64'(irq_done_out), 64'd1);
    irq_ack_in = 1'b1;
    tick();
    irq_ack_in = 1'b0;
    check("t1_irq_ack", 64'(irq_done_out), 64'd0);

    // fill past capacity while engine busy, then drain in order
    ddma_send_busy_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(16'(i + 1), 32'h1000 + 32'(i * 16), 32'd16);
      tick();
      check("t2_fill_count", 64'(count_out), 64'((i < 4) ? i + 1 : 4));
      check("t2_fill_ready", 64'(push_ready_out), 64'((i >= 3) ? 0 : 1));
    end
    push_valid_in = 1'b0;
    ddma_send_busy_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_cmd("t2_cmd");
      check("t2_dest", 64'(ddma_send_dest_out), 64'(k + 1));
      check("t2_addr", 64'(ddma_send_addr_out), 64'h1000 + 64'(k * 16));
      check("t2_count", 64'(count_out), 64'(3 - k));
      ddma_send_busy_in = 1'b1;
      tick();
      check("t2_cmd_drop", 64'(ddma_send_cmd_out), 64'd0);
      ddma_send_busy_in = 1'b0;
      tick();
      tick();
      check("t2_done", 64'(done_count_out), 64'(2 + k));
    end
    repeat (3) tick();
    check("t2_no_fifth", 64'(ddma_send_cmd_out), 64'd0);
    check("t2_done_final", 64'(done_count_out), 64'd5);

    // zero-size descriptor completes without a command
    irq_ack_in = 1'b1;
    tick();
    irq_ack_in = 1'b0;
    check("t3_irq_clr", 64'(irq_done_out), 64'd0);
    push(16'h0033, 32'h2000, 32'd0);
    tick();
    check("t3_count_a", 64'(count_out), 64'd1);
    push(16'h0044, 32'h3000, 32'd32);
    tick();
    push_valid_in = 1'b0;
    check("t3_nocmd", 64'(ddma_send_cmd_out), 64'd0);
    check("t3_dest0", 64'(ddma_send_dest_out), 64'h0033);
    check("t3_count_pp", 64'(count_out), 64'd1);
    tick();
    check("t3_done0", 64'(done_count_out), 64'd6);
    check("t3_irq", 64'(irq_done_out), 64'd1);
    check("t3_nocmd2", 64'(ddma_send_cmd_out), 64'd0);
    tick();
    check("t3_cmd_b", 64'(ddma_send_cmd_out), 64'd1);
    check("t3_size_b", 64'(ddma_send_size_out), 64'd32);
    check("t3_addr_b", 64'(ddma_send_addr_out), 64'h3000);
    ddma_send_busy_in = 1'b1;
    tick();
    ddma_send_busy_in = 1'b0;
    tick();
    tick();
    check("t3_done_b", 64'(done_count_out), 64'd7);

    // flush while engine busy discards queued work
    ddma_send_busy_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(16'h0050 + 16'(i), 32'h4000 + 32'(i), 32'd8);
      tick();
    end
    push_valid_in = 1'b0;
    check("t4_count3", 64'(count_out), 64'd3);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    check("t4_flush_count", 64'(count_out), 64'd0);
    check("t4_flush_ready", 64'(push_ready_out), 64'd1);
    ddma_send_busy_in = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen = seen | ddma_send_cmd_out;
    end
    check("t4_no_cmd", 64'(seen), 64'd0);
    check("t4_done", 64'(done_count_out), 64'd7);

    // engine never responds: timeout after 8 command cycles
    push(16'h0066, 32'h5000, 32'd8);
    tick();
    push(16'h0077, 32'h6000, 32'd24);
    tick();
    push_valid_in = 1'b0;
    check("t5_cmd", 64'(ddma_send_cmd_out), 64'd1);
    check("t5_dest", 64'(ddma_send_dest_out), 64'h0066);
    hi = 1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (ddma_send_cmd_out !== 1'b1) break;
      hi++;
    end
    check("t5_cmd_cycles", 64'(hi), 64'd8);
    check("t5_tmo", 64'(timeout_err_out), 64'd1);
    check("t5_done", 64'(done_count_out), 64'd7);
    tick();
    check("t5_next_cmd", 64'(ddma_send_cmd_out), 64'd1);
    check("t5_next_dest", 64'(ddma_send_dest_out), 64'h0077);
    check("t5_next_addr", 64'(ddma_send_addr_out), 64'h6000);
    ddma_send_busy_in = 1'b1;
    tick();
    ddma_send_busy_in = 1'b0;
    tick();
    tick();
    check("t5_done_next", 64'(done_count_out), 64'd8);
    check("t5_irq", 64'(irq_done_out), 64'd1);

    // ack coinciding with DONE: set wins; ack alone clears
    push(16'h0088, 32'h7000, 32'd4);
    tick();
    push_valid_in = 1'b0;
    tick();
    check("t6_cmd", 64'(ddma_send_cmd_out), 64'd1);
    ddma_send_busy_in = 1'b1;
    tick();
    ddma_send_busy_in = 1'b0;
    tick();
    irq_ack_in = 1'b1;
    tick();
    check("t6_irq_set_wins", 64'(irq_done_out), 64'd1);
    check("t6_done", 64'(done_count_out), 64'd9);
    tick();
    irq_ack_in = 1'b0;
    check("t6_irq_ack", 64'(irq_done_out), 64'd0);

    // reset during RUN clears everything
    push(16'h0099, 32'h8000, 32'd40);
    tick();
    push_valid_in = 1'b0;
    tick();
    check("t7_cmd", 64'(ddma_send_cmd_out), 64'd1);
    ddma_send_busy_in = 1'b1;
    tick();
    check("t7_run", 64'(ddma_send_cmd_out), 64'd0);
    push(16'h00AA, 32'h9000, 32'd12);
    tick();
    push_valid_in = 1'b0;
    check("t7_count1", 64'(count_out), 64'd1);
    reset = 1'b0;
    tick();
    check("t7_count", 64'(count_out), 64'd0);
    check("t7_ready", 64'(push_ready_out), 64'd1);
    check("t7_dest", 64'(ddma_send_dest_out), 64'd0);
    check("t7_addr", 64'(ddma_send_addr_out), 64'd0);
    check("t7_size", 64'(ddma_send_size_out), 64'd0);
    check("t7_done", 64'(done_count_out), 64'd0);
    check("t7_tmo", 64'(timeout_err_out), 64'd0);
    check("t7_irq", 64'(irq_done_out), 64'd0);
    reset = 1'b1;
    tick();
    ddma_send_busy_in = 1'b0;
    repeat (3) tick();
    check("t7_post_cmd", 64'(ddma_send_cmd_out), 64'd0);
    check("t7_post_done", 64'(done_count_out), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
